vga_scan_driver: RTL
====================

Name: vga_scan_driver

Overview:
Display-side end of the pixel interface. It generates 640x480@60 Hz VGA timing from CLOCK_50 and publishes the current scan coordinate (X_pix/Y_pix) to the game/draw logic. It samples the returned 12-bit pixel_color, blanks it outside the visible area, and drives the VGA pins. It also emits a once-per-frame tick so game-state updates can align to vertical blank instead of free-running counters.

Parameters:
CLK_DIV, 2, CLOCK_50 cycles per pixel (pixel_clk enable period)
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
pixel_color  input  12  color for the coordinate presented one pixel earlier; [3:0]=R, [7:4]=G, [11:8]=B
X_pix  output  10  current horizontal count, 0..799
Y_pix  output  10  current vertical count, 0..524
H_visible  output  1  high when X_pix < H_VISIBLE
V_visible  output  1  high when Y_pix < V_VISIBLE
pixel_clk  output  1  one-CLOCK_50-cycle enable pulse, once every CLK_DIV cycles
frame_tick  output  1  one-CLOCK_50-cycle pulse when Y_pix enters V_VISIBLE (start of vblank)
frame_cnt  output  16  frames completed, wraps 65535->0
VGA_R  output  4  red to DAC
VGA_G  output  4  green to DAC
VGA_B  output  4  blue to DAC
VGA_HS  output  1  horizontal sync, active low
VGA_VS  output  1  vertical sync, active low

Behaviour:
- Clock and reset: one clock, CLOCK_50. reset_n is asynchronous and active-low.
- Reset values: all counters 0, X_pix=0, Y_pix=0, pixel_clk=0, frame_tick=0, frame_cnt=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1.
- Reset mid-frame: outputs return to reset values immediately, without waiting for a clock edge. Scan restarts at (0,0) on the first pixel_clk after release.
- Divider: counts 0..CLK_DIV-1. pixel_clk is high on the cycle the divider equals CLK_DIV-1. All scan state updates only on pixel_clk cycles.
- Horizontal counter:
  - H_TOTAL = sum of the four H params = 800.
  - Increments on pixel_clk. At H_TOTAL-1 it wraps to 0 and steps the vertical counter.
- Vertical counter:
  - V_TOTAL = 525.
  - At V_TOTAL-1, on a horizontal wrap, it wraps to 0 and frame_cnt increments.
- frame_tick: asserted for exactly the single CLOCK_50 cycle following the pixel_clk on which Y_pix changes to V_VISIBLE (480). Exactly one pulse per frame.
- Output pipeline (1 pixel period):
  - On each pixel_clk, pixel_color is registered to VGA_R/G/B if the coordinate presented during the previous pixel period was visible; otherwise 0.
  - HS/VS are computed from that same delayed coordinate, so sync and color stay aligned.
  - The game logic therefore has a full pixel period (2 CLOCK_50 cycles) to answer a coordinate.
- Sync windows:
  - VGA_HS is low when the delayed h count is in [H_VISIBLE+H_FRONT, +H_SYNC-1] = [656,751].
  - VGA_VS is low when the delayed v count is in [490,491].
- Blanking: visible = H_visible && V_visible of the delayed coordinate. pixel_color is ignored outside the visible area. No X/Z ever reaches the pins.
- Widths: 10-bit counters are sufficient for H_TOTAL/V_TOTAL ≤ 1023. Parameter sets exceeding this are not supported.

Decomposition:
- Package vga_pkg:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL/sync start-end localparams.
  - Typedef color12_t as a packed struct {b[3:0], g[3:0], r[3:0]}, shared with the game/draw logic.
- One sub-module, vga_axis_counter: parameterised visible/front/sync/back; inputs enable and async reset; outputs count, visible, sync_n and wrap pulse. Instantiated twice (horizontal, vertical), with the horizontal wrap driving the vertical enable.

Test Plan:
- Release reset_n -> pixel_clk pulses every 2 cycles; X_pix steps 0,1,2…; line period 1600 cycles; X_pix wraps 799->0 while Y_pix increments.
- Full frame -> VGA_HS low for 192 cycles per line starting one pixel after X_pix=656; VGA_VS low for 2 lines (3200 cycles); frame period 840000 cycles; frame_cnt 0->1.
- Run 3 frames -> exactly 3 frame_tick pulses, each 1 cycle wide, coincident with Y_pix becoming 480.
- Hold pixel_color=12'h00F -> visible region shows VGA_R=F, G=0, B=0; with 12'hFFF, output during X_pix 640..799 or Y_pix ≥480 is RGB=0.
- Drive pixel_color as a function of X_pix (e.g. {2'b0,X_pix}) -> VGA output at each pixel equals the value for the coordinate one pixel_clk earlier.
- Assert reset_n low at X_pix=700, Y_pix=100 -> HS/VS=1 and RGB=0 before the next edge; after release the scan restarts at (0,0) with frame_cnt=0.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : 640x480@60 Hz VGA timing constants, derived totals and sync
//               windows, the 12-bit colour type shared with the game/draw
//               logic, and a small window-compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Width of the scan counters; totals above 1023 are not supported.
    localparam int VGA_COUNT_W = 10;

    localparam int VGA_CLK_DIV = 2;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL      = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL      = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // Field order matches the pixel_color bus: [11:8]=B, [7:4]=G, [3:0]=R.
    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } color12_t;

    // True when value lies in the inclusive window [lo, hi].
    function automatic logic in_window(
        input logic [VGA_COUNT_W-1:0] value,
        input logic [VGA_COUNT_W-1:0] lo,
        input logic [VGA_COUNT_W-1:0] hi
    );
        return (value >= lo) && (value <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One scan axis (horizontal or vertical). Counts 0..TOTAL-1 on
//               each enable, flags the visible region and the active-low sync
//               window, and pulses wrap on the enable that returns to 0.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               enable  - advance the count this cycle
//               count   - current position on this axis
//               visible - count < VISIBLE
//               sync_n  - low while count is inside the sync window
//               wrap    - enable is high and count is at TOTAL-1
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic [VGA_COUNT_W-1:0] count,
    output logic                   visible,
    output logic                   sync_n,
    output logic                   wrap
);

    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

    localparam logic [VGA_COUNT_W-1:0] C_LAST       = VGA_COUNT_W'(TOTAL - 1);
    localparam logic [VGA_COUNT_W-1:0] C_VISIBLE    = VGA_COUNT_W'(VISIBLE);
    localparam logic [VGA_COUNT_W-1:0] C_SYNC_START = VGA_COUNT_W'(VISIBLE + FRONT);
    localparam logic [VGA_COUNT_W-1:0] C_SYNC_END   = VGA_COUNT_W'(VISIBLE + FRONT + SYNC - 1);

    logic [VGA_COUNT_W-1:0] r_count;
    logic                   w_wrap;

    assign w_wrap = enable && (r_count == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + VGA_COUNT_W'(1);
            end
        end
    end

    assign count   = r_count;
    assign visible = (r_count < C_VISIBLE);
    assign sync_n  = !in_window(r_count, C_SYNC_START, C_SYNC_END);
    assign wrap    = w_wrap;

endmodule
`default_nettype wire

// File: rtl/vga_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_driver
// Description : VGA timing generator and pixel output stage. Divides CLOCK_50
//               down to the pixel rate, scans X/Y, publishes the coordinate to
//               the game logic, registers the returned colour one pixel later
//               together with the matching sync levels, and emits a
//               once-per-frame tick at the start of vertical blank.
// Ports       : CLOCK_50    - system clock
//               reset_n     - asynchronous active-low reset
//               pixel_color - colour answered for the presented coordinate
//               X_pix/Y_pix - current scan coordinate
//               H_visible/V_visible - coordinate inside the visible area
//               pixel_clk   - one-cycle pixel-rate enable
//               frame_tick  - one-cycle pulse as Y_pix enters vblank
//               frame_cnt   - completed frames, free-running
//               VGA_R/G/B, VGA_HS, VGA_VS - DAC and sync pins
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [11:0] pixel_color,
    output logic [9:0]  X_pix,
    output logic [9:0]  Y_pix,
    output logic        H_visible,
    output logic        V_visible,
    output logic        pixel_clk,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Last visible line; the line after it is the first line of vblank.
    localparam logic [VGA_COUNT_W-1:0] C_V_LAST_VISIBLE = VGA_COUNT_W'(V_VISIBLE - 1);

    // ------------------------------------------------------------------
    // Pixel-rate enable
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             w_pix_en;

    assign w_pix_en = (r_div == C_DIV_LAST);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan axes: the horizontal wrap is the vertical step
    // ------------------------------------------------------------------
    logic [VGA_COUNT_W-1:0] w_h_count;
    logic [VGA_COUNT_W-1:0] w_v_count;
    logic                   w_h_visible;
    logic                   w_v_visible;
    logic                   w_h_sync_n;
    logic                   w_v_sync_n;
    logic                   w_h_wrap;
    logic                   w_v_wrap;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .enable  (w_pix_en),
        .count   (w_h_count),
        .visible (w_h_visible),
        .sync_n  (w_h_sync_n),
        .wrap    (w_h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .enable  (w_h_wrap),
        .count   (w_v_count),
        .visible (w_v_visible),
        .sync_n  (w_v_sync_n),
        .wrap    (w_v_wrap)
    );

    // ------------------------------------------------------------------
    // Frame tick and frame counter
    // ------------------------------------------------------------------
    logic        r_frame_tick;
    logic [15:0] r_frame_cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            // Registered so the pulse lands in the cycle Y_pix reads V_VISIBLE.
            r_frame_tick <= w_h_wrap && (w_v_count == C_V_LAST_VISIBLE);
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: colour and sync are both taken from the coordinate that
    // was presented during the pixel period just ending, so they stay
    // aligned on the pins one pixel behind X_pix/Y_pix.
    // ------------------------------------------------------------------
    color12_t w_color;
    color12_t r_color;
    logic     r_hs;
    logic     r_vs;

    assign w_color = pixel_color;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_color <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
        end else if (w_pix_en) begin
            r_color <= (w_h_visible && w_v_visible) ? w_color : '0;
            r_hs    <= w_h_sync_n;
            r_vs    <= w_v_sync_n;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign X_pix      = w_h_count;
    assign Y_pix      = w_v_count;
    assign H_visible  = w_h_visible;
    assign V_visible  = w_v_visible;
    assign pixel_clk  = w_pix_en;
    assign frame_tick = r_frame_tick;
    assign frame_cnt  = r_frame_cnt;
    assign VGA_R      = r_color.r;
    assign VGA_G      = r_color.g;
    assign VGA_B      = r_color.b;
    assign VGA_HS     = r_hs;
    assign VGA_VS     = r_vs;

endmodule
`default_nettype wire
